mem_write_sequencer: RTL and testbench
======================================

MEM_WRITE_SEQUENCER -- requirements
Module: mem_write_sequencer

Interface
REQ-001 SHALL provide parameter: VERIFY, 1, when 1 read back and compare all four bytes after writing; when 0 skip readback.
REQ-002 SHALL provide port: clk  input  1  single clock; every register updates on its rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset; sampled on the clk rising edge.
REQ-004 SHALL provide port: start  input  1  request to write word_in; sampled only in IDLE.
REQ-005 SHALL provide port: word_in  input  32  word to store; byte k = word_in[8k+7:8k] goes to address k.
REQ-006 SHALL provide port: mem_rdata  input  8  combinational read data from the downstream 4-byte memory at mem_addr.
REQ-007 SHALL provide port: mem_data  output  8  byte presented to the memory.
REQ-008 SHALL provide port: mem_store  output  1  store strobe to the memory.
REQ-009 SHALL provide port: mem_addr  output  2  byte address to the memory.
REQ-010 SHALL provide port: busy  output  1  high while a transfer is in progress.
REQ-011 SHALL provide port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port: mismatch  output  4  bit k set when readback of byte k differed from the expected byte.
REQ-013 SHALL provide port: error  output  1  OR of mismatch; valid from the done pulse until the next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, READ, DONE; all outputs are registered (driven from state and registers, with no combinational input-to-output path).
REQ-015 IDLE: when start=1 at an edge, the block SHALL latch word_in into an internal 32-bit register, clear mismatch, set the byte index to 0 and go to WRITE; otherwise it SHALL stay in IDLE.
REQ-016 WRITE: for each byte index k=0..3 on consecutive cycles, the block SHALL drive mem_addr=k, mem_data=latched byte k and mem_store=1; after k=3 it SHALL go to READ if VERIFY=1, otherwise to DONE.
REQ-017 READ: for each k=0..3 on consecutive cycles, the block SHALL drive mem_addr=k, mem_store=0 and mem_data=0; at the end of each cycle it SHALL compare mem_rdata with latched byte k and set mismatch[k] if they differ; after k=3 it SHALL go to DONE.
REQ-018 DONE: the block SHALL hold done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-019 busy SHALL be 1 in WRITE and READ and 0 in IDLE and DONE.
REQ-020 Latency: with start accepted at edge E0, WRITE SHALL occupy cycles 1-4 and READ cycles 5-8, with done in cycle 9 (VERIFY=1) or cycle 5 (VERIFY=0).
REQ-021 The byte index SHALL be a 2-bit counter that wraps from 3 to 0 on the state exit; no other wrap is permitted.
REQ-022 start SHALL be ignored in WRITE, READ and DONE; changes to word_in after acceptance SHALL NOT affect the transfer.
REQ-023 start held continuously high SHALL begin a new transfer on the first IDLE edge after DONE, giving back-to-back transfers with one IDLE cycle between them.
REQ-024 Outside WRITE, mem_store SHALL be 0 and mem_data SHALL be 0; in IDLE and DONE, mem_addr SHALL be 0.
REQ-025 mismatch and error SHALL hold their values through IDLE until the next accepted start clears them.

Reset
REQ-026 When reset=1 at an edge, the block SHALL force state=IDLE, byte index=0, latched word=0, mem_data=0, mem_store=0, mem_addr=0, busy=0, done=0, mismatch=0 and error=0.
REQ-027 Reset SHALL take priority over start and over any state, including mid-WRITE; mem_store SHALL be 0 in the cycle after the reset edge, and no further bytes SHALL be written.
REQ-028 The first start SHALL be accepted at the first edge with reset=0 and start=1.

Verification
REQ-029 Basic write, VERIFY=1, ideal memory model: start with word_in=32'hDEADBEEF -> mem_store=1 for 4 cycles carrying addr/data 0/EF, 1/BE, 2/AD, 3/DE; then 4 READ cycles; done in cycle 9; mismatch=4'b0000, error=0.
REQ-030 Fault injection: memory model forces byte 2 to read 8'h00, word 32'h11223344 -> mismatch=4'b0100, error=1, held until the next start.
REQ-031 VERIFY=0: start with word 32'h01020304 -> 4 store cycles, done in cycle 5, mem_store never high after cycle 4, mismatch=0.
REQ-032 Reset mid-WRITE: reset asserted in cycle 2 -> next cycle mem_store=0, busy=0, state IDLE, mem_addr=0; a subsequent start performs a full, correct transfer.
REQ-033 Ignored start plus back-to-back: start pulsed during READ with a different word_in -> no effect; start held high -> second transfer begins one cycle after the done pulse.
REQ-034 Input stability: word_in changed every cycle after acceptance -> bytes written equal the word latched at acceptance.

Source files
------------

// File: rtl/mem_write_sequencer.sv
// Writes a latched 32-bit word into a 4-byte memory one byte per cycle and,
// optionally, reads the bytes back and flags any byte that differs.
module mem_write_sequencer #(
    parameter bit VERIFY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] word_in,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_data,
    output logic        mem_store,
    output logic [1:0]  mem_addr,
    output logic        busy,
    output logic        done,
    output logic [3:0]  mismatch,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        mem_store_q, mem_store_d;
    logic [1:0]  mem_addr_q, mem_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  mismatch_q, mismatch_d;
    logic        error_q, error_d;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state logic; outputs are decoded from the next state so they land in flops.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        mismatch_d = mismatch_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WRITE;
                    idx_d      = 2'd0;
                    word_d     = word_in;
                    mismatch_d = 4'b0000;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = VERIFY ? READ : DONE;
                end else begin
                    state_d = WRITE;
                end
            end
            READ: begin
                idx_d = idx_q + 2'd1;
                if (mem_rdata != byte_of(word_q, idx_q)) begin
                    mismatch_d[idx_q] = 1'b1;
                end else begin
                    mismatch_d = mismatch_q;
                end
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase

        mem_data_d  = 8'h00;
        mem_store_d = 1'b0;
        mem_addr_d  = 2'd0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            WRITE: begin
                mem_data_d  = byte_of(word_d, idx_d);
                mem_store_d = 1'b1;
                mem_addr_d  = idx_d;
                busy_d      = 1'b1;
            end
            READ: begin
                mem_addr_d = idx_d;
                busy_d     = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
        error_d = |mismatch_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            word_q      <= 32'h0000_0000;
            mem_data_q  <= 8'h00;
            mem_store_q <= 1'b0;
            mem_addr_q  <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 4'b0000;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            mem_data_q  <= mem_data_d;
            mem_store_q <= mem_store_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            error_q     <= error_d;
        end
    end

    assign mem_data  = mem_data_q;
    assign mem_store = mem_store_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mem_write_sequencer.sv
// Bench for mem_write_sequencer: one VERIFY=1 and one VERIFY=0 instance share
// stimulus and are checked each cycle against a transfer-phase reference model.
module tb_mem_write_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] word_in;
    logic        fault_en;
    logic [1:0]  fault_byte;

    logic [7:0] rd_v, data_v, rd_n, data_n;
    logic       store_v, busy_v, done_v, err_v, store_n, busy_n, done_n, err_n;
    logic [1:0] addr_v, addr_n;
    logic [3:0] mm_v, mm_n;
    logic [7:0] mem_v [4];
    logic [7:0] mem_n [4];

    int checks = 0;
    int errors = 0;

    int          ph  [2];
    logic [31:0] wd  [2];
    logic [3:0]  mmx [2];
    int          len [2] = '{9, 5};
    bit          ver [2] = '{1'b1, 1'b0};

    typedef struct {
        logic        rst;
        logic        start;
        logic [31:0] word;
        logic [7:0]  x_data;
        logic [1:0]  x_addr;
        logic        x_store;
        logic        x_busy;
        logic        x_done;
        logic [3:0]  x_mm;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    mem_write_sequencer #(.VERIFY(1'b1)) dut_v (
        .clk(clk), .reset(reset), .start(start), .word_in(word_in), .mem_rdata(rd_v),
        .mem_data(data_v), .mem_store(store_v), .mem_addr(addr_v), .busy(busy_v),
        .done(done_v), .mismatch(mm_v), .error(err_v));

    mem_write_sequencer #(.VERIFY(1'b0)) dut_n (
        .clk(clk), .reset(reset), .start(start), .word_in(word_in), .mem_rdata(rd_n),
        .mem_data(data_n), .mem_store(store_n), .mem_addr(addr_n), .busy(busy_n),
        .done(done_n), .mismatch(mm_n), .error(err_n));

    // Ideal byte memories; when fault_en is set, one address reads back as zero.
    always_ff @(posedge clk) begin
        if (store_v) mem_v[addr_v] <= data_v;
        if (store_n) mem_n[addr_n] <= data_n;
    end
    assign rd_v = (fault_en && fault_byte == addr_v) ? 8'h00 : mem_v[addr_v];
    assign rd_n = (fault_en && fault_byte == addr_n) ? 8'h00 : mem_n[addr_n];

    function automatic logic [7:0] bt(input logic [31:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs follow from how many cycles have passed since acceptance.
    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            int         p;
            logic       e_store, e_busy, e_done;
            logic [1:0] e_addr;
            logic [7:0] e_data;
            p       = ph[i];
            e_store = (p >= 1 && p <= 4);
            e_busy  = (p >= 1 && p < len[i]);
            e_done  = (p == len[i]);
            e_addr  = 2'd0;
            e_data  = 8'h00;
            if (e_store) begin
                e_addr = 2'(p - 1);
                e_data = bt(wd[i], p - 1);
            end else if (ver[i] && p >= 5 && p <= 8) begin
                e_addr = 2'(p - 5);
            end
            if (i == 0) begin
                chk("v.store", 32'(store_v), 32'(e_store));
                chk("v.addr",  32'(addr_v),  32'(e_addr));
                chk("v.data",  32'(data_v),  32'(e_data));
                chk("v.busy",  32'(busy_v),  32'(e_busy));
                chk("v.done",  32'(done_v),  32'(e_done));
                chk("v.mismatch", 32'(mm_v), 32'(mmx[i]));
                chk("v.error", 32'(err_v),   32'(|mmx[i]));
            end else begin
                chk("n.store", 32'(store_n), 32'(e_store));
                chk("n.addr",  32'(addr_n),  32'(e_addr));
                chk("n.data",  32'(data_n),  32'(e_data));
                chk("n.busy",  32'(busy_n),  32'(e_busy));
                chk("n.done",  32'(done_n),  32'(e_done));
                chk("n.mismatch", 32'(mm_n), 32'(mmx[i]));
                chk("n.error", 32'(err_n),   32'(|mmx[i]));
            end
        end
    endtask

    task automatic update_model(input logic r, input logic s, input logic [31:0] w);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                ph[i] = 0; wd[i] = 32'h0; mmx[i] = 4'h0;
            end else if (ph[i] == 0) begin
                if (s) begin
                    ph[i] = 1; wd[i] = w; mmx[i] = 4'h0;
                end
            end else if (ph[i] == len[i]) begin
                ph[i] = 0;
            end else begin
                if (ver[i] && ph[i] >= 5 && ph[i] <= 8) begin
                    int         k;
                    logic [7:0] rv;
                    k  = ph[i] - 5;
                    rv = (fault_en && fault_byte == 2'(k)) ? 8'h00 : bt(wd[i], k);
                    if (rv != bt(wd[i], k)) mmx[i][k] = 1'b1;
                end
                ph[i]++;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [31:0] w);
        @(negedge clk);
        check_model();
        reset = r; start = s; word_in = w;
        @(posedge clk);
        update_model(r, s, w);
    endtask

    initial begin
        int dn, nst, last_st, d1, s2;
        reset = 1'b1; start = 1'b0; word_in = 32'h0;
        fault_en = 1'b0; fault_byte = 2'd0;
        for (int i = 0; i < 2; i++) begin ph[i] = 0; wd[i] = 32'h0; mmx[i] = 4'h0; end

        tbl[0] = '{1'b0, 1'b1, 32'hDEADBEEF, 8'hEF, 2'd0, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h00000000, 8'hBE, 2'd1, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h00000000, 8'hAD, 2'd2, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h00000000, 8'hDE, 2'd3, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[4] = '{1'b0, 1'b0, 32'h00000000, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 4'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h00000000, 8'h00, 2'd1, 1'b0, 1'b1, 1'b0, 4'h0};
        tbl[6] = '{1'b0, 1'b0, 32'h00000000, 8'h00, 2'd2, 1'b0, 1'b1, 1'b0, 4'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h00000000, 8'h00, 2'd3, 1'b0, 1'b1, 1'b0, 4'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h00000000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[9] = '{1'b0, 1'b0, 32'h00000000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0};

        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h12345678);

        // Basic DEADBEEF transfer on the verifying instance, cycle by cycle.
        for (int r = 0; r < 10; r++) begin
            step(tbl[r].rst, tbl[r].start, tbl[r].word);
            #1;
            chk($sformatf("tbl%0d.data", r),  32'(data_v),  32'(tbl[r].x_data));
            chk($sformatf("tbl%0d.addr", r),  32'(addr_v),  32'(tbl[r].x_addr));
            chk($sformatf("tbl%0d.store", r), 32'(store_v), 32'(tbl[r].x_store));
            chk($sformatf("tbl%0d.busy", r),  32'(busy_v),  32'(tbl[r].x_busy));
            chk($sformatf("tbl%0d.done", r),  32'(done_v),  32'(tbl[r].x_done));
            chk($sformatf("tbl%0d.mm", r),    32'(mm_v),    32'(tbl[r].x_mm));
            chk($sformatf("tbl%0d.err", r),   32'(err_v),   32'(|tbl[r].x_mm));
        end

        // Byte 2 reads back as zero: mismatch held through idle until next start.
        fault_en = 1'b1; fault_byte = 2'd2;
        step(1'b0, 1'b1, 32'h11223344);
        repeat (8) step(1'b0, 1'b0, 32'h0);
        #1;
        chk("fault.done", 32'(done_v), 32'd1);
        chk("fault.mm",   32'(mm_v),   32'(4'b0100));
        chk("fault.err",  32'(err_v),  32'd1);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        #1;
        chk("fault.mm_held",  32'(mm_v),  32'(4'b0100));
        chk("fault.err_held", 32'(err_v), 32'd1);
        fault_en = 1'b0;
        step(1'b0, 1'b1, 32'h55667788);
        #1;
        chk("fault.mm_clr",  32'(mm_v),  32'(4'b0000));
        chk("fault.err_clr", 32'(err_v), 32'd0);
        repeat (10) step(1'b0, 1'b0, 32'h0);

        // Non-verifying instance: four stores, done in cycle 5.
        dn = 0; nst = 0; last_st = 0;
        for (int n = 1; n <= 12; n++) begin
            step(1'b0, (n == 1), (n == 1) ? 32'h01020304 : 32'h0);
            #1;
            if (done_n && dn == 0) dn = n;
            if (store_n) begin nst++; last_st = n; end
        end
        chk("nover.done_cycle", 32'(dn), 32'd5);
        chk("nover.stores", 32'(nst), 32'd4);
        chk("nover.last_store", 32'(last_st), 32'd4);

        // Reset sampled in cycle 2 of a write kills the transfer immediately.
        step(1'b0, 1'b1, 32'hA5A55A5A);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        #1;
        chk("rst.store", 32'(store_v), 32'd0);
        chk("rst.busy",  32'(busy_v),  32'd0);
        chk("rst.addr",  32'(addr_v),  32'd0);
        chk("rst.store_n", 32'(store_n), 32'd0);
        step(1'b0, 1'b1, 32'hCAFEF00D);
        repeat (10) step(1'b0, 1'b0, 32'h0);

        // start held high with word_in changing every cycle: back-to-back transfers.
        d1 = 0; s2 = 0;
        for (int n = 1; n <= 26; n++) begin
            step(1'b0, 1'b1, (n == 1) ? 32'h0BADF00D : $urandom);
            #1;
            if (done_v && d1 == 0) d1 = n;
            if (store_v && d1 != 0 && s2 == 0) s2 = n;
        end
        chk("b2b.first_done", 32'(d1), 32'd9);
        chk("b2b.restart", 32'(s2), 32'(d1 + 2));
        step(1'b0, 1'b0, 32'h0);
        repeat (12) step(1'b0, 1'b0, 32'h0);

        // Random traffic with occasional resets and read faults.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                fault_en   = $urandom_range(0, 1) == 1;
                fault_byte = 2'($urandom_range(0, 3));
            end
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom);
        end
        step(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
